debounce_scan_ctrl: RTL and testbench

Time-multiplexed debounce controller for many slow digital inputs (limit switches, buttons, E-stop chains).
- One shared evaluation engine replaces per-pin counters.
- A round-robin scheduler visits one channel per slot and keeps each channel's count in a register array.
- Sits between the raw input pins and the host-visible input registers.

---
 rtl/debounce_scan_pkg.sv | 43 ++++
 rtl/debounce_scan_ctrl_if.sv | 38 +++
 rtl/debounce_scan_sync.sv | 33 +++
 rtl/debounce_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_debounce_scan_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/debounce_scan_pkg.sv
// -----------------------------------------------------------------------------
// debounce_scan_pkg
// Shared definitions for the time-multiplexed debounce controller:
//   - scan_state_e : scan FSM states (S_WAIT, S_LOAD, S_EVAL)
//   - clog2        : constant ceil(log2) helper
//   - idx_width / cnt_width : derived width rules, usable with any parameter set
//   - IDX_W / CNT_W : widths for the default configuration (8 channels, delay 16)
// -----------------------------------------------------------------------------
package debounce_scan_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_LOAD = 2'd1,
    S_EVAL = 2'd2
  } scan_state_e;

  // ceil(log2(value)); clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Channel index width; never zero so a single-channel build still has a port.
  function automatic int idx_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  // Stable-sample counter width; holds 0..delay.
  function automatic int cnt_width(input int delay);
    return (clog2(delay + 1) < 1) ? 1 : clog2(delay + 1);
  endfunction

  localparam int IDX_W = idx_width(8);
  localparam int CNT_W = cnt_width(16);

endpackage

// File: rtl/debounce_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// debounce_scan_ctrl_if
// Pin-side bundle of the debounce controller.
//   din      : raw asynchronous inputs            (master -> slave)
//   dout     : debounced levels                   (slave -> master)
//   rise     : 1-clk pulse on dout 0->1           (slave -> master)
//   fall     : 1-clk pulse on dout 1->0           (slave -> master)
//   scan_idx : channel under evaluation (debug)   (slave -> master)
// With DEBOUNCE_SCAN_IRQ_EN defined it also carries:
//   irq_clr  : per-channel pending clear          (master -> slave)
//   irq      : OR of pending change flags         (slave -> master)
// -----------------------------------------------------------------------------
interface debounce_scan_ctrl_if
  import debounce_scan_pkg::*;
#(
  parameter int CHANNELS = 8
) ();

  localparam int IDX_BITS = idx_width(CHANNELS);

  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] dout;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [IDX_BITS-1:0] scan_idx;

`ifdef DEBOUNCE_SCAN_IRQ_EN
  logic [CHANNELS-1:0] irq_clr;
  logic                irq;

  modport master (output din, irq_clr, input dout, rise, fall, scan_idx, irq);
  modport slave  (input din, irq_clr, output dout, rise, fall, scan_idx, irq);
`else
  modport master (output din, input dout, rise, fall, scan_idx);
  modport slave  (input din, output dout, rise, fall, scan_idx);
`endif

endinterface

// File: rtl/debounce_scan_sync.sv
// -----------------------------------------------------------------------------
// debounce_scan_sync
// WIDTH-bit two-flop synchronizer for asynchronous inputs; both stages reset
// to 0.
//   clk : system clock
//   rst : asynchronous, active-high reset
//   d   : asynchronous inputs
//   q   : synchronized outputs (two clocks of latency)
// -----------------------------------------------------------------------------
module debounce_scan_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // NOTE: non-blocking assignments make both stages sample their old values
  // on the same edge, so the chain really is two flops deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// -----------------------------------------------------------------------------
// debounce_scan_ctrl
// Time-multiplexed debounce controller. A single evaluation engine visits one
// channel per scan slot (PRESCALE clocks) in round-robin order, keeping each
// channel's stable-sample count in a register array. A channel's output
// changes after DELAY+1 consecutive agreeing samples of that channel.
//
// Parameters: CHANNELS (>= 1), DELAY (threshold), PRESCALE (>= 3 clk/slot)
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : debounce_scan_ctrl_if.slave (din in; dout/rise/fall/scan_idx out)
// Optional feature macro DEBOUNCE_SCAN_IRQ_EN: adds a sticky per-channel
// pending register set by rise/fall, cleared by bus.irq_clr (set wins), and a
// registered bus.irq = |pending.
// -----------------------------------------------------------------------------
module debounce_scan_ctrl
  import debounce_scan_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DELAY    = 16,
  parameter int PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  debounce_scan_ctrl_if.slave  bus
);

  localparam int IDX_BITS = idx_width(CHANNELS);
  localparam int CNT_BITS = cnt_width(DELAY);
  localparam int PRE_BITS = idx_width(PRESCALE);

  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(CHANNELS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(DELAY);
  localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_q;

  debounce_scan_sync #(.WIDTH(CHANNELS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.din),
    .q   (sync_q)
  );

  // ---------------------------------------------------------------------------
  // Slot prescaler: the terminal count is the slot tick
  // ---------------------------------------------------------------------------
  logic [PRE_BITS-1:0] pre_q;
  logic                slot_tick;

  assign slot_tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= slot_tick ? '0 : pre_q + PRE_BITS'(1);
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  scan_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (slot_tick) state_d = S_LOAD;
      S_LOAD:  state_d = S_EVAL;
      S_EVAL:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-channel state and the working copy of the visited channel
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] idx_q;
  logic [CNT_BITS-1:0] cnt_q [CHANNELS];
  logic [CHANNELS-1:0] dout_q, rise_q, fall_q;

  logic                sample_q;
  logic                cur_out_q;
  logic [CNT_BITS-1:0] cur_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q  <= 1'b0;
      cur_out_q <= 1'b0;
      cur_cnt_q <= '0;
    end else if (state_q == S_LOAD) begin
      sample_q  <= sync_q[idx_q];
      cur_out_q <= dout_q[idx_q];
      cur_cnt_q <= cnt_q[idx_q];
    end
  end

  // Debounce rule. While the output is low the count climbs towards DELAY on
  // high samples; while it is high the count drains towards 0 on low samples.
  // A disagreeing sample snaps the count back to the settled end.
  logic [CNT_BITS-1:0] next_cnt;
  logic                next_out;
  logic                do_rise;
  logic                do_fall;

  always_comb begin
    next_cnt = cur_cnt_q;
    next_out = cur_out_q;
    do_rise  = 1'b0;
    do_fall  = 1'b0;
    case ({cur_out_q, sample_q})
      2'b01: begin
        if (cur_cnt_q == CNT_MAX) begin
          next_out = 1'b1;
          do_rise  = 1'b1;
        end else begin
          next_cnt = cur_cnt_q + CNT_BITS'(1);
        end
      end
      2'b00: next_cnt = '0;
      2'b10: begin
        if (cur_cnt_q == '0) begin
          next_out = 1'b0;
          do_fall  = 1'b1;
        end else begin
          next_cnt = cur_cnt_q - CNT_BITS'(1);
        end
      end
      default: next_cnt = CNT_MAX;
    endcase
  end

  // Write-back happens only on the edge leaving S_EVAL; a reset before that
  // edge discards the working copy. rise/fall default low every clock so a
  // pulse lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      dout_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      // NOTE: the count array is reset explicitly; every channel must start
      // from a known count, which a plain memory macro would not give us.
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      if (state_q == S_EVAL) begin
        cnt_q[idx_q]  <= next_cnt;
        dout_q[idx_q] <= next_out;
        rise_q[idx_q] <= do_rise;
        fall_q[idx_q] <= do_fall;
        idx_q         <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_BITS'(1);
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.scan_idx = idx_q;

`ifdef DEBOUNCE_SCAN_IRQ_EN
  // ---------------------------------------------------------------------------
  // Sticky change flags. The set term is OR-ed in after the clear mask, so a
  // change arriving in the same cycle as its clear survives.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] pending_q;
  logic                irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~bus.irq_clr) | rise_q | fall_q;
      irq_q     <= |pending_q;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debounce_scan_ctrl
// Bench for debounce_scan_ctrl with CHANNELS=4, DELAY=3, PRESCALE=4.
// Cycle numbering: cyc counts rising edges since reset release (first edge is
// cyc 1). Channel c is sampled on edge 4n+5 (n = slot, c = n mod 4) from the
// synchronized value present after edge 4n+4, and its outputs update on edge
// 4n+6. An input driven just after edge k is synchronized after edge k+2.
// Expected rise/fall events are queued when stimulus is issued; a monitor pops
// one entry for every cycle in which the DUT shows a rise or fall pulse.
// -----------------------------------------------------------------------------
module tb_debounce_scan_ctrl;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  debounce_scan_ctrl_if #(.CHANNELS(CH)) bus ();

  debounce_scan_ctrl #(
    .CHANNELS (CH),
    .DELAY    (3),
    .PRESCALE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int       cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] dout;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: every pulse cycle must match the next queued event.
  always @(negedge clk) begin
    if (!rst && ((bus.rise | bus.fall) != '0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {24'd0, bus.rise, bus.fall}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("ev_cycle", cyc, mon_ev.cyc);
        check("ev_rise",  bus.rise, mon_ev.rise);
        check("ev_fall",  bus.fall, mon_ev.fall);
        check("ev_dout",  bus.dout, mon_ev.dout);
      end
    end
  end

  // Wait until just after edge c (returns on a falling edge).
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reset for two cycles, then release with din applied right away (k = 0).
  task automatic restart(input logic [3:0] din_v);
    @(negedge clk);
    rst     = 1'b1;
    bus.din = '0;
    @(negedge clk);
    @(negedge clk);
    bus.din = din_v;
    rst     = 1'b0;
  endtask

  task automatic end_phase(input string name, input logic [3:0] dout_exp);
    check({name, "_events_left"}, exp_q.size(), 0);
    check({name, "_dout"}, bus.dout, dout_exp);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.din = '0;
`ifdef DEBOUNCE_SCAN_IRQ_EN
    bus.irq_clr = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_dout",     bus.dout, 0);
    check("rst_rise",     bus.rise, 0);
    check("rst_fall",     bus.fall, 0);
    check("rst_scan_idx", bus.scan_idx, 0);

    // Phase A: ch2 held high rises on its 4th sample (edge 61 -> update 62);
    // ch1 high for samples at 9/25/41 then low for 57 never rises.
    exp_q.push_back('{cyc: 62, rise: 4'b0100, fall: 4'b0000, dout: 4'b0100});
    restart(4'b0110);
    at(48); bus.din[1] = 1'b0;
    at(57); check("cnt1_partial", dut.cnt_q[1], 3);
    at(58); check("cnt1_cleared", dut.cnt_q[1], 0);
    at(80); end_phase("phase_a", 4'b0100);

    // Phase B: ch0 rises at 54; lows at 69/85, one high at 101 restores the
    // count, then four lows at 117..165 give the fall at 166.
    exp_q.push_back('{cyc: 54,  rise: 4'b0001, fall: 4'b0000, dout: 4'b0001});
    exp_q.push_back('{cyc: 166, rise: 4'b0000, fall: 4'b0001, dout: 4'b0000});
    restart(4'b0001);
    at(60); bus.din[0] = 1'b0;
    at(86); check("cnt0_two_lows", dut.cnt_q[0], 1);
    at(90); bus.din[0] = 1'b1;
`ifdef DEBOUNCE_SCAN_IRQ_EN
    at(100); check("irq_after_rise", bus.irq, 1); bus.irq_clr = 4'b0001;
    at(101); bus.irq_clr = '0;
`endif
    at(102); check("cnt0_restored", dut.cnt_q[0], 3);
`ifdef DEBOUNCE_SCAN_IRQ_EN
    check("irq_cleared", bus.irq, 0);
`endif
    at(108); bus.din[0] = 1'b0;
    at(150); check("dout0_after_3_lows", bus.dout, 4'b0001);
`ifdef DEBOUNCE_SCAN_IRQ_EN
    at(166); bus.irq_clr = 4'b0001;
    at(167); bus.irq_clr = '0;
    at(168); check("irq_set_wins", bus.irq, 1);
    at(170); bus.irq_clr = 4'b0001;
    at(171); bus.irq_clr = '0;
    at(172); check("irq_cleared_late", bus.irq, 0);
`endif
    at(180); end_phase("phase_b", 4'b0000);

    // Phase C: all four high together rise in channel order, one slot apart.
    exp_q.push_back('{cyc: 54, rise: 4'b0001, fall: 4'b0000, dout: 4'b0001});
    exp_q.push_back('{cyc: 58, rise: 4'b0010, fall: 4'b0000, dout: 4'b0011});
    exp_q.push_back('{cyc: 62, rise: 4'b0100, fall: 4'b0000, dout: 4'b0111});
    exp_q.push_back('{cyc: 66, rise: 4'b1000, fall: 4'b0000, dout: 4'b1111});
    restart(4'b1111);
    at(70); end_phase("phase_c", 4'b1111);

    // Phase D: reach dout=1010 with partial counts, reset mid-evaluation of ch3.
    exp_q.push_back('{cyc: 58, rise: 4'b0010, fall: 4'b0000, dout: 4'b0010});
    exp_q.push_back('{cyc: 66, rise: 4'b1000, fall: 4'b0000, dout: 4'b1010});
    restart(4'b1010);
    at(66); bus.din = 4'b0101;
    at(81);
    check("pre_rst_dout", bus.dout, 4'b1010);
    check("pre_rst_cnt0", dut.cnt_q[0], 1);
    check("pre_rst_cnt1", dut.cnt_q[1], 2);
    end_phase("phase_d", 4'b1010);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout",     bus.dout, 0);
    check("async_rst_rise",     bus.rise, 0);
    check("async_rst_fall",     bus.fall, 0);
    check("async_rst_scan_idx", bus.scan_idx, 0);
    for (int i = 0; i < CH; i++) check($sformatf("async_rst_cnt%0d", i), dut.cnt_q[i], 0);

    // Scan restarts at idx 0 with prescaler 0: same absolute timing as before.
    exp_q.push_back('{cyc: 54, rise: 4'b0001, fall: 4'b0000, dout: 4'b0001});
    exp_q.push_back('{cyc: 62, rise: 4'b0100, fall: 4'b0000, dout: 4'b0101});
    restart(4'b0101);
    at(5); check("restart_idx_slot0", bus.scan_idx, 0);
    at(6); check("restart_idx_slot1", bus.scan_idx, 1);
    at(70); end_phase("phase_e", 4'b0101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
